// File: rtl/spike_delta_enc_if.sv
// ============================================================================
// Module  : spike_delta_enc_if
// Brief   : Sample/spike bus between a sample source and spike_delta_encoder.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface spike_delta_enc_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] sample_in;
  logic             sample_valid;
  logic             sample_ready;
  logic             spike_up;
  logic             spike_dn;
  logic [WIDTH-1:0] recon;
  logic             busy;

  modport master (
    output sample_in, sample_valid,
    input  sample_ready, spike_up, spike_dn, recon, busy
  );

  modport slave (
    input  sample_in, sample_valid,
    output sample_ready, spike_up, spike_dn, recon, busy
  );
endinterface

`default_nettype wire

// File: rtl/spike_delta_encoder.sv
// ============================================================================
// Module  : spike_delta_encoder
// Brief   : Delta-modulation encoder turning samples into UP/DOWN spikes.
//           Optional idle leak of the reconstruction level: ENC_LEAK_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module spike_delta_encoder #(
  parameter int WIDTH          = 8,
  parameter int STEP           = 4,
  parameter int THRESH         = 8,
  parameter int REFRACT_CYCLES = 3,
  parameter int LEAK_PERIOD    = 16
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  spike_delta_enc_if.slave     bus
);

  localparam int                c_ref_eff  = (REFRACT_CYCLES < 1) ? 1 : REFRACT_CYCLES;
  localparam int                c_ref_w    = (c_ref_eff > 1) ? $clog2(c_ref_eff) : 1;
  localparam logic [c_ref_w-1:0] c_ref_load = c_ref_w'(c_ref_eff - 1);
  localparam logic [WIDTH:0]    c_step     = (WIDTH+1)'(STEP);
  localparam logic signed [WIDTH:0] c_thresh = (WIDTH+1)'(THRESH);
  localparam logic [WIDTH-1:0]  c_max      = '1;

  // Oscillation-free convergence relies on THRESH >= STEP.
  if (STEP < 1 || THRESH < STEP || LEAK_PERIOD < 1) begin : g_param_check
    $error("spike_delta_encoder: illegal STEP/THRESH/LEAK_PERIOD");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_REFRACT = 2'd2
  } state_t;

  state_t              r_state,   w_state_nxt;
  logic [WIDTH-1:0]    r_sample,  w_sample_nxt;
  logic [WIDTH-1:0]    r_recon,   w_recon_nxt;
  logic [c_ref_w-1:0]  r_refract, w_refract_nxt;
  logic                r_spike_up, w_spike_up_nxt;
  logic                r_spike_dn, w_spike_dn_nxt;

  logic                w_accept;
  logic signed [WIDTH:0] w_diff;
  logic [WIDTH:0]      w_recon_up;
  logic                w_fire_up;
  logic                w_fire_dn;

`ifdef ENC_LEAK_EN
  localparam int                 c_leak_w    = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  localparam logic [c_leak_w-1:0] c_leak_last = c_leak_w'(LEAK_PERIOD - 1);
  logic [c_leak_w-1:0] r_leak, w_leak_nxt;
`endif

  assign w_accept   = bus.sample_valid && (r_state == S_IDLE);
  assign w_diff     = $signed({1'b0, r_sample}) - $signed({1'b0, r_recon});
  assign w_recon_up = {1'b0, r_recon} + c_step;
  assign w_fire_up  = (w_diff >= c_thresh);
  assign w_fire_dn  = (w_diff <= -c_thresh);

  always_comb begin
    w_state_nxt    = r_state;
    w_sample_nxt   = r_sample;
    w_recon_nxt    = r_recon;
    w_refract_nxt  = r_refract;
    w_spike_up_nxt = 1'b0;
    w_spike_dn_nxt = 1'b0;
`ifdef ENC_LEAK_EN
    w_leak_nxt     = '0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_sample_nxt = bus.sample_in;
          w_state_nxt  = S_COMPARE;
        end
`ifdef ENC_LEAK_EN
        // Accept takes priority over a leak falling on the same edge.
        else if (r_leak == c_leak_last) begin
          w_recon_nxt = (r_recon == '0) ? '0 : r_recon - WIDTH'(1);
        end else begin
          w_leak_nxt = r_leak + c_leak_w'(1);
        end
`endif
      end
      S_COMPARE: begin
        if (w_fire_up) begin
          w_spike_up_nxt = 1'b1;
          w_recon_nxt    = w_recon_up[WIDTH] ? c_max : w_recon_up[WIDTH-1:0];
          w_refract_nxt  = c_ref_load;
          w_state_nxt    = S_REFRACT;
        end else if (w_fire_dn) begin
          w_spike_dn_nxt = 1'b1;
          w_recon_nxt    = ({1'b0, r_recon} < c_step) ? '0 : r_recon - c_step[WIDTH-1:0];
          w_refract_nxt  = c_ref_load;
          w_state_nxt    = S_REFRACT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REFRACT: begin
        if (r_refract == '0) begin
          w_state_nxt = S_COMPARE;
        end else begin
          w_refract_nxt = r_refract - c_ref_w'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sample   <= '0;
      r_recon    <= '0;
      r_refract  <= '0;
      r_spike_up <= 1'b0;
      r_spike_dn <= 1'b0;
`ifdef ENC_LEAK_EN
      r_leak     <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_sample   <= w_sample_nxt;
      r_recon    <= w_recon_nxt;
      r_refract  <= w_refract_nxt;
      r_spike_up <= w_spike_up_nxt;
      r_spike_dn <= w_spike_dn_nxt;
`ifdef ENC_LEAK_EN
      r_leak     <= w_leak_nxt;
`endif
    end
  end

  assign bus.sample_ready = (r_state == S_IDLE);
  assign bus.busy         = (r_state == S_COMPARE) || (r_state == S_REFRACT);
  assign bus.spike_up     = r_spike_up;
  assign bus.spike_dn     = r_spike_dn;
  assign bus.recon        = r_recon;

endmodule

`default_nettype wire
